// File: rtl/dsp_pkg.sv
// dsp_pkg: shared constants for the DSP48E2 multiply-add primitive wrapper.
// OPMODE layout is {W[1:0], Z[2:0], Y[1:0], X[1:0]}.
package dsp_pkg;

    // Native DSP48E2 port widths.
    localparam int A_W = 30;
    localparam int B_W = 18;
    localparam int C_W = 48;
    localparam int P_W = 48;

    // X=M, Y=M, W=0; Z selects the addend.
    localparam logic [8:0] OPMODE_MUL_ADD_C = 9'b00_011_01_01;  // Z = C
    localparam logic [8:0] OPMODE_MUL_ADD_P = 9'b00_010_01_01;  // Z = P (feedback)

    localparam logic [3:0] ALUMODE_ADD    = 4'b0000;             // Z + W + X + Y
    localparam logic [4:0] INMODE_DEFAULT = 5'b00000;            // A2/B2 paths, no pre-adder

endpackage

// File: rtl/dsp_muladd_ctrl.sv
// dsp_muladd_ctrl: valid (and optional acc) shift register plus clock-enable
// generation for dsp_muladd_pipe. Optional feature macro: DSP_MULADD_ACC_EN.
//
// Handshake: a beat moves on an edge where valid and ready are both high.
// in_ready = adv = !out_valid | out_ready, so the pipe only stalls when a
// result is waiting and downstream refuses it; in_ready is combinational
// from out_ready.
module dsp_muladd_ctrl
    import dsp_pkg::*;
#(
    parameter int stages = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    input  logic out_ready,
`ifdef DSP_MULADD_ACC_EN
    input  logic acc,
    output logic acc_p,
`endif
    output logic in_ready,
    output logic out_valid,
    output logic ce,
    output logic cep
);

    logic [stages-1:0] vld;
    logic              adv;
    logic              vld_p;   // valid of the beat presented at the P-register input

    assign out_valid = vld[stages-1];
    assign adv       = !vld[stages-1] || out_ready;
    assign in_ready  = adv;
    assign ce        = adv;
    // Bubbles never load P, so y holds the last result between beats.
    assign cep       = adv && vld_p;

    generate
        if (stages == 1) begin : g_vld_one
            assign vld_p = in_valid;
            // Single valid bit tracking the P register.
            always_ff @(posedge clock) begin
                if (reset)    vld <= '0;
                else if (adv) vld <= in_valid;
            end
        end else begin : g_vld_multi
            assign vld_p = vld[stages-2];
            // Valid bits shift one stage per advance.
            always_ff @(posedge clock) begin
                if (reset)    vld <= '0;
                else if (adv) vld <= {vld[stages-2:0], in_valid};
            end
        end
    endgenerate

`ifdef DSP_MULADD_ACC_EN
    generate
        if (stages == 1) begin : g_acc_one
            assign acc_p = acc;
        end else begin : g_acc_multi
            logic [stages-2:0] acc_sr;
            assign acc_p = acc_sr[stages-2];
            // acc travels alongside its beat to pick OPMODE at the P stage.
            always_ff @(posedge clock) begin
                if (reset)    acc_sr <= '0;
                else if (adv) acc_sr <= (stages == 2) ? acc_sr'(acc)
                                                      : {acc_sr[(stages>2 ? stages-3 : 0):0], acc};
            end
        end
    endgenerate
`endif

endmodule

// File: rtl/dsp_muladd_pipe.sv
// dsp_muladd_pipe: pipelined signed y = a*b + c (or a*b + previous y) written
// to map onto one DSP48E2 (AREG/BREG/CREG, MREG, PREG chosen by stages).
// Optional feature macro: DSP_MULADD_ACC_EN (per-beat Z=P accumulation).
module dsp_muladd_pipe
    import dsp_pkg::*;
#(
    parameter int width  = 8,
    parameter int stages = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [width-1:0] c,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] y
);

    logic ce;
    logic cep;
    logic z_sel_p;
    logic [8:0] opmode;

`ifdef DSP_MULADD_ACC_EN
    logic acc_p;
    dsp_muladd_ctrl #(.stages(stages)) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .acc_p     (acc_p),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .ce        (ce),
        .cep       (cep)
    );
    assign opmode = acc_p ? OPMODE_MUL_ADD_P : OPMODE_MUL_ADD_C;
`else
    logic unused_acc;
    assign unused_acc = acc;
    dsp_muladd_ctrl #(.stages(stages)) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .ce        (ce),
        .cep       (cep)
    );
    assign opmode = OPMODE_MUL_ADD_C;
`endif

    assign z_sel_p = (opmode == OPMODE_MUL_ADD_P);

    // Sign-extend operands onto the native DSP port widths.
    logic signed [A_W-1:0] a_x;
    logic signed [B_W-1:0] b_x;
    logic signed [C_W-1:0] c_x;
    assign a_x = {{(A_W-width){a[width-1]}}, a};
    assign b_x = {{(B_W-width){b[width-1]}}, b};
    assign c_x = {{(C_W-width){c[width-1]}}, c};

    logic signed [A_W-1:0] a_s;
    logic signed [B_W-1:0] b_s;
    logic signed [C_W-1:0] c_s;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] m_s;
    logic signed [P_W-1:0] c_m;   // addend aligned with the multiplier output
    logic signed [P_W-1:0] z;
    logic signed [P_W-1:0] p_r;

    generate
        if (stages == 3) begin : g_abc_reg
            // Input registers (AREG/BREG/CREG).
            always_ff @(posedge clock) begin
                if (reset) begin
                    a_s <= '0;
                    b_s <= '0;
                    c_s <= '0;
                end else if (ce) begin
                    a_s <= a_x;
                    b_s <= b_x;
                    c_s <= c_x;
                end
            end
        end else begin : g_abc_comb
            assign a_s = a_x;
            assign b_s = b_x;
            assign c_s = c_x;
        end
    endgenerate

    assign prod = P_W'(a_s) * P_W'(b_s);

    generate
        if (stages >= 2) begin : g_m_reg
            // Multiplier register (MREG); C is delayed with it so it meets
            // the product of the same beat at the P adder.
            always_ff @(posedge clock) begin
                if (reset) begin
                    m_s <= '0;
                    c_m <= '0;
                end else if (ce) begin
                    m_s <= prod;
                    c_m <= c_s;
                end
            end
        end else begin : g_m_comb
            assign m_s = prod;
            assign c_m = c_s;
        end
    endgenerate

    assign z = z_sel_p ? p_r : c_m;

    // Output register (PREG); loads only for real beats.
    always_ff @(posedge clock) begin
        if (reset)    p_r <= '0;
        else if (cep) p_r <= m_s + z;
    end

    assign y = p_r[width-1:0];

endmodule

// File: tb/tb_dsp_muladd_pipe.sv
// tb_dsp_muladd_pipe: self-checking bench for dsp_muladd_pipe (width=8).
// Main DUT uses stages=3; two extra instances cover stages=1 and stages=2.
// Honours DSP_MULADD_ACC_EN when the build defines it.
module tb_dsp_muladd_pipe;

    localparam int W = 8;

    // ---------------- clock / reset / DUTs ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a, b, c;
    logic         acc;

    logic         in_ready, out_valid;
    logic [W-1:0] y;
    logic         in_ready2, out_valid2;
    logic [W-1:0] y2;
    logic         in_ready1, out_valid1;
    logic [W-1:0] y1;

    always #5 clk = ~clk;

    dsp_muladd_pipe #(.width(W), .stages(3)) dut (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );
    dsp_muladd_pipe #(.width(W), .stages(2)) dut_s2 (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .c(c), .acc(acc),
        .out_valid(out_valid2), .out_ready(out_ready), .y(y2)
    );
    dsp_muladd_pipe #(.width(W), .stages(1)) dut_s1 (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .c(c), .acc(acc),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         acc;
    } beat_t;

    typedef struct packed {
        logic         ov;
        logic         ir;
        logic [W-1:0] y;
    } trace_t;

    logic [W-1:0] exp_q[$];
    longint       acc_state;

    beat_t        beats_q[$];
    trace_t       trace_q[$];
    logic [W-1:0] obs_q[$];
    int           obs_cyc_q[$];
    int           acc_cyc_q[$];

    // Result = a*b + addend in plain integer arithmetic; the accumulator is
    // the previous result, and only the low W bits are visible.
    function automatic void model_push(input beat_t bt);
        longint p;
        p = longint'($signed(bt.a)) * longint'($signed(bt.b));
`ifdef DSP_MULADD_ACC_EN
        if (bt.acc) p = p + acc_state;
        else        p = p + longint'($signed(bt.c));
`else
        p = p + longint'($signed(bt.c));
`endif
        acc_state = p;
        exp_q.push_back(p[W-1:0]);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        acc_state = 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        acc       = 1'b0;
        model_reset();
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    // Streams beats_q into the main DUT; out_ready is low for stall_len
    // cycles starting at cycle stall_at. Records accepted/emitted cycles,
    // emitted values and a per-cycle trace.
    task automatic drive(input int stall_at, input int stall_len, input int max_cyc);
        int cyc  = 0;
        int sent = 0;
        int n    = beats_q.size();
        bit fi, fo;
        trace_t t;
        trace_q.delete(); obs_q.delete(); obs_cyc_q.delete(); acc_cyc_q.delete();
        while ((sent < n || obs_q.size() < n) && cyc < max_cyc) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < n) begin
                in_valid = 1'b1;
                a = beats_q[sent].a; b = beats_q[sent].b;
                c = beats_q[sent].c; acc = beats_q[sent].acc;
            end else begin
                in_valid = 1'b0;
                a = W'($urandom); b = W'($urandom); c = W'($urandom); acc = 1'($urandom);
            end
            #1;
            t.ov = out_valid; t.ir = in_ready; t.y = y;
            trace_q.push_back(t);
            fi = in_valid && in_ready;
            fo = out_valid && out_ready;
            if (fi) begin
                model_push(beats_q[sent]);
                acc_cyc_q.push_back(cyc);
                sent++;
            end
            if (fo) begin
                obs_q.push_back(y);
                obs_cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    function automatic beat_t rand_beat(input bit with_acc);
        beat_t bt;
        bt.a = W'($urandom); bt.b = W'($urandom); bt.c = W'($urandom);
        bt.acc = with_acc ? 1'($urandom_range(0, 1)) : 1'b0;
        return bt;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int spurious = 0;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 8'd9; b = 8'd9; c = 8'd9; acc = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", y); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL reset_ignored_beat: got %0d outputs expected 0", spurious); end
    endtask

    task automatic test_basic();
        do_reset(2);
        beats_q.delete();
        beats_q.push_back('{8'd3, 8'd4, 8'd5, 1'b0});
        drive(1000, 0, 40);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d expected 1", obs_q.size());
        end else begin
            checks++; if (obs_q[0] !== 8'h11) begin errors++; $display("FAIL basic_y: got %h expected 11", obs_q[0]); end
            checks++; if (obs_cyc_q[0] - acc_cyc_q[0] != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", obs_cyc_q[0] - acc_cyc_q[0]); end
        end
    endtask

    task automatic test_signed_wrap();
        logic [W-1:0] want [2];
        want[0] = 8'hF3; want[1] = 8'h00;
        do_reset(2);
        beats_q.delete();
        beats_q.push_back('{8'hFE, 8'd7, 8'd1, 1'b0});
        beats_q.push_back('{8'd16, 8'd16, 8'd0, 1'b0});
        drive(1000, 0, 40);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL signed_count: got %0d expected 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin errors++; $display("FAIL signed_y%0d: got %h expected %h", i, obs_q[i], want[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        do_reset(2);
        beats_q.delete();
        for (int i = 0; i < 10; i++) beats_q.push_back(rand_beat(1'b0));
        drive(1000, 0, 60);
        checks++;
        if (obs_q.size() != 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_y%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
            if (i > 0 && obs_cyc_q[i] != obs_cyc_q[i-1] + 1) gaps++;
        end
        checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        do_reset(2);
        beats_q.delete();
        for (int i = 0; i < 10; i++) beats_q.push_back(rand_beat(1'b0));
        drive(4, 4, 80);
        checks++;
        if (obs_q.size() != 10) begin errors++; $display("FAIL stall_count: got %0d expected 10", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_y%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        held = trace_q[4].y;
        checks++; if (trace_q[4].ov !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", trace_q[4].ov); end
        for (int k = 4; k < 8; k++) begin
            checks++; if (trace_q[k].ir !== 1'b0) begin errors++; $display("FAIL stall_in_ready_c%0d: got %b expected 0", k, trace_q[k].ir); end
            checks++; if (trace_q[k].y !== held || trace_q[k].ov !== 1'b1) begin
                errors++; $display("FAIL stall_hold_c%0d: got y=%h v=%b expected y=%h v=1", k, trace_q[k].y, trace_q[k].ov, held);
            end
        end
    endtask

    task automatic test_acc();
        logic [W-1:0] want [3];
`ifdef DSP_MULADD_ACC_EN
        want[0] = 8'd7; want[1] = 8'd11; want[2] = 8'd36;
`else
        want[0] = 8'd7; want[1] = 8'd4;  want[2] = 8'd25;
`endif
        do_reset(2);
        beats_q.delete();
        beats_q.push_back('{8'd2, 8'd3, 8'd1, 1'b0});
        beats_q.push_back('{8'd1, 8'd4, 8'd0, 1'b1});
        beats_q.push_back('{8'd5, 8'd5, 8'd0, 1'b1});
        drive(1000, 0, 40);
        checks++;
        if (obs_q.size() != 3) begin
            errors++; $display("FAIL acc_count: got %0d expected 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin errors++; $display("FAIL acc_y%0d: got %h expected %h", i, obs_q[i], want[i]); end
            end
        end
        // Random mixture of acc and non-acc beats with a mid-stream stall.
        do_reset(2);
        beats_q.delete();
        for (int i = 0; i < 12; i++) beats_q.push_back(rand_beat(1'b1));
        drive(5, 3, 80);
        checks++;
        if (obs_q.size() != 12) begin errors++; $display("FAIL acc_rand_count: got %0d expected 12", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL acc_rand_y%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        logic [W-1:0] want;
        do_reset(2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'd5; b = 8'd5; c = 8'd3; acc = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 8'h1C) begin
            errors++; $display("FAIL mid_pre_reset: got v=%b y=%h expected v=1 y=1c", out_valid, y);
        end
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL mid_y: got %h expected 00", y); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        reset = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL mid_stale: got %0d outputs expected 0", spurious); end
`ifdef DSP_MULADD_ACC_EN
        want = 8'd6;
`else
        want = 8'd15;
`endif
        beats_q.delete();
        beats_q.push_back('{8'd2, 8'd3, 8'd9, 1'b1});
        drive(1000, 0, 40);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== want) begin
            errors++; $display("FAIL mid_acc_from_zero: got n=%0d y=%h expected n=1 y=%h",
                               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx, want);
        end
    endtask

    task automatic test_stages();
        int lat1 = -1, lat2 = -1, lat3 = -1;
        logic [W-1:0] v1 = 8'hxx, v2 = 8'hxx, v3 = 8'hxx;
        do_reset(2);
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'd3; b = 8'd4; c = 8'd5; acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (lat1 < 0 && out_valid1 === 1'b1) begin lat1 = k; v1 = y1; end
            if (lat2 < 0 && out_valid2 === 1'b1) begin lat2 = k; v2 = y2; end
            if (lat3 < 0 && out_valid  === 1'b1) begin lat3 = k; v3 = y;  end
            @(posedge clk); #1;
        end
        checks++; if (lat1 != 1) begin errors++; $display("FAIL s1_latency: got %0d expected 1", lat1); end
        checks++; if (lat2 != 2) begin errors++; $display("FAIL s2_latency: got %0d expected 2", lat2); end
        checks++; if (lat3 != 3) begin errors++; $display("FAIL s3_latency: got %0d expected 3", lat3); end
        checks++; if (v1 !== 8'h11) begin errors++; $display("FAIL s1_y: got %h expected 11", v1); end
        checks++; if (v2 !== 8'h11) begin errors++; $display("FAIL s2_y: got %h expected 11", v2); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; acc = 1'b0;
        acc_state = 0;
        test_reset();
        test_basic();
        test_signed_wrap();
        test_back_to_back();
        test_backpressure();
        test_acc();
        test_reset_mid();
        test_stages();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
